// File: rtl/counter_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : counter_bank_scheduler
// Purpose  : NUM_CH up/down counters sharing one incrementer. A round-robin
//            arbiter picks at most one requesting channel per cycle. Each
//            channel has its own signed/unsigned and wrap/saturate setting,
//            and its own sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module counter_bank_scheduler #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH-1:0]          dir,
    input  logic [NUM_CH-1:0]          cfg_signed,
    input  logic [NUM_CH-1:0]          cfg_saturate,
    input  logic [NUM_CH-1:0]          clr,
    input  logic [NUM_CH-1:0]          ovf_clr,
    input  logic [$clog2(NUM_CH)-1:0]  rd_sel,
    output logic [NUM_CH-1:0]          grant,
    output logic [NUM_CH-1:0]          ovf,
    output logic [WIDTH-1:0]           rd_data,
    output logic [2*WIDTH-1:0]         rd_data_ext
);

    localparam int               c_sel_w = $clog2(NUM_CH);
    localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_umax  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_smax  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_smin  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]   r_count [NUM_CH];
    logic [NUM_CH-1:0]  r_grant;
    logic [NUM_CH-1:0]  r_ovf;
    logic [c_sel_w-1:0] r_ptr;

    logic [NUM_CH-1:0]  w_elig;
    logic [NUM_CH-1:0]  w_gnt_oh;
    logic               w_any;
    logic [c_sel_w-1:0] w_ptr_nxt;
    logic [WIDTH-1:0]   w_cur;
    logic               w_sgn;
    logic               w_sat;
    logic               w_dn;
    logic               w_at_limit;
    logic [WIDTH-1:0]   w_next;
    logic [NUM_CH-1:0]  w_ovf_set;
    logic [WIDTH-1:0]   w_rd;
    logic               w_rd_sgn;

    // A channel being cleared this cycle never competes for the adder.
    assign w_elig = req & ~clr;

    // Round-robin pick: scan offsets from the pointer, first eligible wins.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_oh  = '0;
        w_ptr_nxt = r_ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!w_any && w_elig[c] && (((int'(r_ptr) + k) % NUM_CH) == c)) begin
                    w_any       = 1'b1;
                    w_gnt_oh[c] = 1'b1;
                    w_ptr_nxt   = (c == NUM_CH - 1) ? '0 : c_sel_w'(c + 1);
                end
            end
        end
    end

    // Shared step datapath: mux in the winner's state and apply +/-1 with limits.
    always_comb begin
        w_cur = '0;
        w_sgn = 1'b0;
        w_sat = 1'b0;
        w_dn  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_gnt_oh[c]) begin
                w_cur = r_count[c];
                w_sgn = cfg_signed[c];
                w_sat = cfg_saturate[c];
                w_dn  = dir[c];
            end
        end
        // A step from the limit in the stepping direction is an overflow;
        // saturating simply means the count does not move.
        if (w_dn) begin
            w_at_limit = w_sgn ? (w_cur == c_smin) : (w_cur == '0);
        end else begin
            w_at_limit = w_sgn ? (w_cur == c_smax) : (w_cur == c_umax);
        end
        if (w_at_limit && w_sat) begin
            w_next = w_cur;
        end else begin
            w_next = w_dn ? (w_cur - c_one) : (w_cur + c_one);
        end
        w_ovf_set = w_gnt_oh & {NUM_CH{w_at_limit}};
    end

    // State update: counts, registered grant, sticky overflow (set beats clear), pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_count[c] <= '0;
            end
            r_grant <= '0;
            r_ovf   <= '0;
            r_ptr   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr[c]) begin
                    r_count[c] <= '0;
                end else if (w_gnt_oh[c]) begin
                    r_count[c] <= w_next;
                end
            end
            r_grant <= w_gnt_oh;
            r_ovf   <= (r_ovf & ~ovf_clr) | w_ovf_set;
            if (w_any) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    // Readback mux; a select past the last channel matches nothing and reads 0.
    always_comb begin
        w_rd     = '0;
        w_rd_sgn = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_sel == c_sel_w'(c)) begin
                w_rd     = r_count[c];
                w_rd_sgn = cfg_signed[c];
            end
        end
    end

    assign grant       = r_grant;
    assign ovf         = r_ovf;
    assign rd_data     = w_rd;
    assign rd_data_ext = w_rd_sgn ? {{WIDTH{w_rd[WIDTH-1]}}, w_rd} : {{WIDTH{1'b0}}, w_rd};

endmodule
`default_nettype wire

// File: doc/counter_bank_scheduler.md
COUNTER_BANK_SCHEDULER -- requirements
Module: counter_bank_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter NUM_CH, default 4, meaning number of counter channels sharing one adder (legal range 2..8).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_CH  meaning per-channel step request, level-sensitive.
REQ-006 SHALL have port dir  input  NUM_CH  meaning per-channel step direction: 0 = +1, 1 = -1.
REQ-007 SHALL have port cfg_signed  input  NUM_CH  meaning per-channel two's-complement interpretation.
REQ-008 SHALL have port cfg_saturate  input  NUM_CH  meaning per-channel limit mode: 1 = saturate, 0 = wrap.
REQ-009 SHALL have port clr  input  NUM_CH  meaning per-channel synchronous clear of the count.
REQ-010 SHALL have port ovf_clr  input  NUM_CH  meaning per-channel clear of the sticky overflow flag.
REQ-011 SHALL have port rd_sel  input  clog2(NUM_CH)  meaning readback channel select.
REQ-012 SHALL have port grant  output  NUM_CH  meaning registered one-hot of the channel stepped at the previous edge; all-zero if none.
REQ-013 SHALL have port ovf  output  NUM_CH  meaning sticky per-channel overflow flags.
REQ-014 SHALL have port rd_data  output  WIDTH  meaning combinational count[rd_sel].
REQ-015 SHALL have port rd_data_ext  output  2*WIDTH  meaning count[rd_sel], sign-extended if cfg_signed[rd_sel] is 1, else zero-extended.

Function
REQ-016 SHALL arbitrate each cycle among eligible channels (req=1 and clr=0) round-robin; at most one channel is stepped per cycle.
REQ-017 SHALL give highest priority after reset to channel 0; after a grant to channel i, highest priority SHALL move to channel (i+1) mod NUM_CH; with no grant, the pointer SHALL hold.
REQ-018 SHALL update the granted count at the same edge the grant is decided; grant and the new count become visible together one cycle after req is sampled.
REQ-019 SHALL, for a channel holding req continuously, step that channel once per grant; there is no request latching, and dropping req before grant cancels it.
REQ-020 SHALL define limits as 0 and 2^WIDTH-1 (unsigned) or -2^(WIDTH-1) and 2^(WIDTH-1)-1 (signed), using cfg_signed sampled in the step cycle.
REQ-021 SHALL, when a step would cross a limit, wrap modulo 2^WIDTH if cfg_saturate=0, or hold the count at that limit if cfg_saturate=1; in both modes it SHALL set ovf for that channel.
REQ-022 SHALL, on clr[i]=1, set count[i] to 0 at the next edge and exclude channel i from that cycle's arbitration; ovf[i] is unaffected.
REQ-023 SHALL, when ovf_clr[i] and a new overflow on channel i occur in the same cycle, leave ovf[i]=1 (set wins).
REQ-024 SHALL NOT modify stored count bits when cfg_signed or cfg_saturate change; the changes affect only subsequent steps and rd_data_ext.
REQ-025 SHALL produce rd_data and rd_data_ext combinationally from registered counts; an out-of-range rd_sel SHALL return 0.

Reset
REQ-026 SHALL, while reset=1 at an edge, set all counts to 0, grant to 0, ovf to 0, and the priority pointer to channel 0; reset overrides clr, req, and ovf_clr.
REQ-027 SHALL act on the first edge after reset deasserts; there is no extra idle cycle.

Verification (WIDTH=8, NUM_CH=4)
REQ-028 SHALL cover: reset held 2 cycles with req=4'b1111 -> grant=0, all counts 0, ovf=0; on the first cycle after release, grant=4'b0001.
REQ-029 SHALL cover: req=4'b1111, dir=0 held 8 cycles -> grant sequence 0001,0010,0100,1000,0001,0010,0100,1000; every count=2.
REQ-030 SHALL cover: channel 0 unsigned, wrap mode, one down step from 0 -> rd_data=8'hFF, rd_data_ext=16'h00FF, ovf[0]=1; then set cfg_signed[0]=1 -> rd_data_ext=16'hFFFF, count unchanged.
REQ-031 SHALL cover: channel 1 signed, saturate mode, 130 down steps from 0 -> count=8'h80, ovf[1]=1 from the 129th step onward, rd_data_ext=16'hFF80.
REQ-032 SHALL cover: clr[2] and req[2] together with req[3]=1 -> grant=4'b1000, count[2]=0; also ovf_clr[1] coincident with a channel 1 overflow -> ovf[1] stays 1.
REQ-033 SHALL cover: reset asserted mid-sequence with all counts nonzero -> next cycle all counts 0, ovf=0, and the next grant goes to channel 0.
